pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline (F/D/E/M/W). It compares D-stage source usage times (Tuse) against E/M-stage result-ready times (Tnew) to detect RAW hazards. It sequences the multi-cycle MDU with an internal busy counter and stalls ERET behind in-flight MTC0 EPC writes. It drives the F/D enables and the E-stage bubble insert, yields to exception requests, and keeps a saturating stall-cycle performance counter.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu starts (1..15)
DIV_CYCLES, 10, busy cycles after a div/divu starts (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
d_rs_addr  in  5  D-stage rs read address
d_rt_addr  in  5  D-stage rt read address
d_rs_tuse  in  2  cycles until rs needed (0..2; 3 = unused)
d_rt_tuse  in  2  cycles until rt needed (0..2; 3 = unused)
d_is_md  in  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
d_is_eret  in  1  D instr is eret
e_wa  in  5  E-stage destination register
e_tnew  in  2  E-stage cycles until result ready
m_wa  in  5  M-stage destination register
m_tnew  in  2  M-stage cycles until result ready
e_md_start  in  1  E instr starts a mult/div this cycle
e_md_is_div  in  1  qualifies e_md_start: 1 = div, 0 = mult
e_mtc0_epc  in  1  E instr is mtc0 to EPC
m_mtc0_epc  in  1  M instr is mtc0 to EPC
req  in  1  exception/interrupt request from CP0
f_en  out  1  PC/F-reg enable
d_en  out  1  D-reg enable
e_flush  out  1  clear E-reg (insert bubble)
stall  out  1  combined stall indication
md_busy  out  1  MDU busy
stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
- Clock and reset: clk is the clock. reset is synchronous and active-high. While reset=1: md_cnt<=0 and stall_cnt<=0, and outputs are forced to stall=0, f_en=1, d_en=1, e_flush=0, md_busy=0.
- RAW hazard on rs: (d_rs_addr!=0) and ((e_wa==d_rs_addr and e_tnew>d_rs_tuse) or (m_wa==d_rs_addr and m_tnew>d_rs_tuse)). The rt hazard uses the same rule with rt signals. Tuse=3 never stalls, because Tnew is at most 2.
- MD hazard: d_is_md and (md_busy or e_md_start).
- ERET hazard: d_is_eret and (e_mtc0_epc or m_mtc0_epc).
- Combining: stall_raw = OR of all hazards. stall = stall_raw and not req.
- Outputs are combinational (0 cycles latency): f_en = d_en = ~stall, e_flush = stall. The M/W stages are never stalled by this block.
- req=1 masks stall, so the PC can load 0x4180. The pipeline registers perform their own flush on req.
- MDU counter md_cnt, 4 bits:
  - e_md_start=1, req=0 and md_cnt==0: md_cnt <= DIV_CYCLES if e_md_is_div, else MULT_CYCLES.
  - Otherwise, if md_cnt!=0: md_cnt <= md_cnt-1.
  - md_busy = (md_cnt!=0). It is high for exactly N consecutive cycles starting the cycle after the start.
  - e_md_start with req=1 is ignored, because the instruction is flushed.
  - e_md_start while md_cnt!=0 is ignored. The counter keeps decrementing and is not reloaded.
  - req does not cancel an already running count.
- stall_cnt: increments on each clock edge where stall=1 and reset=0. It saturates at 32'hFFFF_FFFF with no wrap.

Test Plan:
- Load-use: e_wa=5, e_tnew=2, d_rs_addr=5, d_rs_tuse=1 -> stall=1, f_en=0, e_flush=1. Next cycle, with m_wa=5, m_tnew=1 -> stall=0.
- Zero register and unused operand: e_wa=0 with d_rs_addr=0, and d_rt_tuse=3 with an address match -> stall=0. stall_cnt stays unchanged.
- MDU: e_md_start=1, e_md_is_div=1 at cycle t -> md_busy=1 for cycles t+1..t+10. d_is_md=1 throughout -> stall=1 for cycles t..t+10 and stall_cnt increases by 11. A mult start gives 5 busy cycles.
- Exception priority: RAW hazard present and req=1 -> stall=0, f_en=1. Also e_md_start=1 with req=1 -> md_busy stays 0.
- ERET: d_is_eret=1, e_mtc0_epc=1 -> stall. Next cycle, m_mtc0_epc=1 -> stall. Following cycle, both 0 -> no stall.
- Reset mid-division: reset at md_cnt=6 -> md_busy=0 and stall_cnt=0 the next cycle. Separately, preloading stall_cnt near 32'hFFFF_FFFF and holding stall=1 -> stall_cnt sticks at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: detects RAW, MDU and ERET hazards,
// tracks MDU busy time and counts stalled cycles (saturating).
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs_addr,
  input  logic [4:0]  d_rt_addr,
  input  logic [1:0]  d_rs_tuse,
  input  logic [1:0]  d_rt_tuse,
  input  logic        d_is_md,
  input  logic        d_is_eret,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  input  logic        e_mtc0_epc,
  input  logic        m_mtc0_epc,
  input  logic        req,
  output logic        f_en,
  output logic        d_en,
  output logic        e_flush,
  output logic        stall,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        haz_rs, haz_rt, haz_md, haz_eret;
  logic        busy_int, stall_int;

  function automatic logic raw_hit(input logic [4:0] addr, input logic [1:0] tuse,
                                   input logic [4:0] ewa, input logic [1:0] etn,
                                   input logic [4:0] mwa, input logic [1:0] mtn);
    return (addr != 5'd0) &&
           (((ewa == addr) && (etn > tuse)) || ((mwa == addr) && (mtn > tuse)));
  endfunction

  always_comb begin
    haz_rs    = raw_hit(d_rs_addr, d_rs_tuse, e_wa, e_tnew, m_wa, m_tnew);
    haz_rt    = raw_hit(d_rt_addr, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew);
    busy_int  = (md_cnt_q != 4'd0) && !reset;
    haz_md    = d_is_md && (busy_int || e_md_start);
    haz_eret  = d_is_eret && (e_mtc0_epc || m_mtc0_epc);
    // req masks the stall so the exception vector can be fetched; reset forces the idle view
    stall_int = (haz_rs || haz_rt || haz_md || haz_eret) && !req && !reset;
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_start && !req && (md_cnt_q == 4'd0)) begin
      md_cnt_d = e_md_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_int && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall     = stall_int;
  assign f_en      = ~stall_int;
  assign d_en      = ~stall_int;
  assign e_flush   = stall_int;
  assign md_busy   = busy_int;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: hazard vector table, multi-cycle MDU/reset/saturation
// sequences, and randomized traffic against a cycle-indexed reference model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs_addr, d_rt_addr, e_wa, m_wa;
  logic [1:0]  d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
  logic        d_is_md, d_is_eret, e_md_start, e_md_is_div, e_mtc0_epc, m_mtc0_epc, req;
  logic        f_en, d_en, e_flush, stall, md_busy;
  logic [31:0] stall_cnt;

  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_is_md(d_is_md), .d_is_eret(d_is_eret),
    .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .e_mtc0_epc(e_mtc0_epc), .m_mtc0_epc(m_mtc0_epc), .req(req),
    .f_en(f_en), .d_en(d_en), .e_flush(e_flush), .stall(stall),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] rs_tuse, rt_tuse;
    logic       is_eret;
    logic [4:0] ewa;
    logic [1:0] etnew;
    logic [4:0] mwa;
    logic [1:0] mtnew;
    logic       e_epc, m_epc, rq;
    logic       exp_stall;
  } vec_t;

  int     n_vec = 0;
  int     n_err = 0;
  longint exp_cnt = 0;
  int     cyc = 0;
  int     md_start_cyc = -100;
  int     md_len = 0;

  // MDU occupancy is modelled as a window of cycle indices after the accepted start
  function automatic bit model_busy();
    return (md_len != 0) && (cyc > md_start_cyc) && (cyc <= md_start_cyc + md_len);
  endfunction

  function automatic bit raw(input int addr, input int tuse);
    if (addr == 0) return 1'b0;
    return ((int'(e_wa) == addr) && (int'(e_tnew) > tuse)) ||
           ((int'(m_wa) == addr) && (int'(m_tnew) > tuse));
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle();
    reset = 0; d_rs_addr = 0; d_rt_addr = 0; d_rs_tuse = 3; d_rt_tuse = 3;
    d_is_md = 0; d_is_eret = 0; e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0;
    e_md_start = 0; e_md_is_div = 0; e_mtc0_epc = 0; m_mtc0_epc = 0; req = 0;
  endtask

  // Called just after a falling edge with inputs applied; checks, then advances one clock.
  task automatic step(input int tbl_exp);
    bit es, eb, start_ok;
    #1;
    eb = !reset && model_busy();
    es = !reset && !req &&
         (raw(d_rs_addr, d_rs_tuse) || raw(d_rt_addr, d_rt_tuse) ||
          (d_is_md && (eb || e_md_start)) ||
          (d_is_eret && (e_mtc0_epc || m_mtc0_epc)));
    check("stall", stall, es);
    check("f_en", f_en, !es);
    check("d_en", d_en, !es);
    check("e_flush", e_flush, es);
    check("md_busy", md_busy, eb);
    check("stall_cnt", stall_cnt, exp_cnt);
    if (tbl_exp >= 0) check("table_stall", stall, tbl_exp);
    start_ok = !reset && e_md_start && !req && !eb;
    @(posedge clk);
    if (reset) begin
      exp_cnt = 0;
      md_len = 0;
    end else begin
      if (es) exp_cnt = (exp_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : exp_cnt + 1;
      if (start_ok) begin
        md_start_cyc = cyc;
        md_len = e_md_is_div ? 10 : 5;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  vec_t tbl[12];
  longint c0;
  int     busy_seen;

  initial begin
    //            rs  rt  rsT rtT eret ewa etn mwa mtn eepc mepc req exp
    tbl[0]  = '{5'd5, 5'd0, 2'd1, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{5'd5, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{5'd0, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{5'd0, 5'd7, 2'd3, 2'd3, 1'b0, 5'd7, 2'd2, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{5'd0, 5'd7, 2'd3, 2'd0, 1'b0, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{5'd5, 5'd0, 2'd1, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{5'd5, 5'd0, 2'd0, 2'd3, 1'b0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{5'd5, 5'd0, 2'd2, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    idle();
    reset = 1;
    @(negedge clk);
    step(0);
    step(0);
    reset = 0;
    step(0);

    for (int i = 0; i < 12; i++) begin
      idle();
      d_rs_addr = tbl[i].rs; d_rt_addr = tbl[i].rt;
      d_rs_tuse = tbl[i].rs_tuse; d_rt_tuse = tbl[i].rt_tuse;
      d_is_eret = tbl[i].is_eret;
      e_wa = tbl[i].ewa; e_tnew = tbl[i].etnew; m_wa = tbl[i].mwa; m_tnew = tbl[i].mtnew;
      e_mtc0_epc = tbl[i].e_epc; m_mtc0_epc = tbl[i].m_epc; req = tbl[i].rq;
      step(int'(tbl[i].exp_stall));
    end

    // Division with a dependent MD instruction waiting in D: 11 stalled cycles
    idle();
    step(-1);
    c0 = exp_cnt;
    d_is_md = 1; e_md_start = 1; e_md_is_div = 1;
    step(1);
    e_md_start = 0;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      busy_seen += int'(md_busy);
      step(1);
    end
    check("div_busy_cycles", busy_seen, 10);
    step(0);
    check("div_stall_delta", longint'(stall_cnt) - c0, 11);

    // Multiply: five busy cycles
    idle();
    e_md_start = 1;
    step(-1);
    e_md_start = 0;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      #1 busy_seen += int'(md_busy);
      step(-1);
    end
    check("mult_busy_cycles", busy_seen, 5);

    // Start under an exception request is dropped
    idle();
    e_md_start = 1; e_md_is_div = 1; req = 1;
    step(0);
    idle();
    #1 check("req_start_ignored", md_busy, 0);
    step(0);

    // Reset while the divider counter sits at 6
    idle();
    d_is_md = 1; e_md_start = 1; e_md_is_div = 1;
    step(1);
    e_md_start = 0;
    for (int i = 0; i < 4; i++) step(1);
    reset = 1;
    step(0);
    reset = 0;
    #1 check("rst_mid_busy", md_busy, 0);
    check("rst_mid_cnt", stall_cnt, 0);
    step(0);

    // Saturation of the stall counter
    idle();
    force dut.stall_cnt_q = 32'hFFFF_FFFC;
    #1 release dut.stall_cnt_q;
    exp_cnt = 64'hFFFF_FFFC;
    #1;
    d_rs_addr = 5'd9; d_rs_tuse = 2'd0; e_wa = 5'd9; e_tnew = 2'd1;
    #1;
    for (int i = 0; i < 6; i++) step(1);
    check("sat_value", stall_cnt, 32'hFFFF_FFFF);
    idle();
    step(0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(99) == 0);
      d_rs_addr   = 5'($urandom_range(3));
      d_rt_addr   = 5'($urandom_range(3));
      d_rs_tuse   = 2'($urandom_range(3));
      d_rt_tuse   = 2'($urandom_range(3));
      e_wa        = 5'($urandom_range(3));
      m_wa        = 5'($urandom_range(3));
      e_tnew      = 2'($urandom_range(2));
      m_tnew      = 2'($urandom_range(2));
      d_is_md     = ($urandom_range(3) == 0);
      d_is_eret   = ($urandom_range(7) == 0);
      e_md_start  = ($urandom_range(9) == 0);
      e_md_is_div = 1'($urandom_range(1));
      e_mtc0_epc  = ($urandom_range(3) == 0);
      m_mtc0_epc  = ($urandom_range(3) == 0);
      req         = ($urandom_range(9) == 0);
      step(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks done", n_vec);
    $fatal(1);
  end

endmodule
